// File: rtl/tacometro.sv
// -----------------------------------------------------------------------------
// tacometro -- windowed speed-sensor pulse counter (tachometer front end)
//
// The raw sensor input is synchronized, glitch-filtered and edge-detected.
// Rising edges are counted over windows delimited by tick_in. The count of
// each completed window is published with a one-cycle count_valid pulse,
// together with a saturation flag and a stall indication derived from
// consecutive empty windows.
//
// Parameters
//   CNT_WIDTH     : width of the per-window pulse count
//   FILTER_LEN    : cycles a new synchronized level must hold (1..255)
//   STALL_WINDOWS : consecutive zero-count windows that flag a stall (1..255)
//
// Ports
//   clk_in      in   system clock, all logic on posedge
//   rst         in   synchronous, active-high reset
//   enable      in   measurement enable
//   tick_in     in   one-cycle window strobe
//   sensor_in   in   raw asynchronous sensor pulse input
//   count_out   out  rising edges counted in the last completed window
//   count_valid out  one-cycle pulse when count_out is updated
//   overflow    out  last completed window saturated
//   stalled     out  motor stalled indication
// -----------------------------------------------------------------------------
module tacometro #(
    parameter int CNT_WIDTH     = 16,
    parameter int FILTER_LEN    = 4,
    parameter int STALL_WINDOWS = 3
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 tick_in,
    input  logic                 sensor_in,
    output logic [CNT_WIDTH-1:0] count_out,
    output logic                 count_valid,
    output logic                 overflow,
    output logic                 stalled
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [7:0]           FILT_LAST = 8'(FILTER_LEN - 1);
    localparam logic [7:0]           STALL_MAX = 8'(STALL_WINDOWS);

    // Sensor front end
    logic       r_sync1;
    logic       r_sync2;
    logic       r_filt;
    logic [7:0] r_filt_cnt;
    logic       r_filt_d;
    logic       r_rise;

    // Measurement FSM and published outputs
    state_t               r_state;
    logic [CNT_WIDTH-1:0] r_win_cnt;
    logic [7:0]           r_stall_cnt;
    logic [CNT_WIDTH-1:0] r_count_out;
    logic                 r_count_valid;
    logic                 r_overflow;
    logic                 r_stalled;

    logic [CNT_WIDTH-1:0] w_cnt_next;
    logic                 w_win_sat;
    logic [7:0]           w_stall_next;

    // -------------------------------------------------------------------------
    // Synchronizer, persistence filter and registered rising-edge detect.
    // The filter counts consecutive cycles in which the synchronized level
    // disagrees with the accepted level; any agreement restarts the count,
    // so pulses shorter than FILTER_LEN cycles never reach the counter.
    // Latency from the first edge that samples a stable high to the window
    // counter increment: 2 (sync) + FILTER_LEN - 1 (filter) + 1 (edge reg)
    // + 1 (counter) = FILTER_LEN + 3 cycles.
    // -------------------------------------------------------------------------
    // NOTE: every clocked block uses non-blocking (<=) assignments so all
    // registers update together from pre-edge values; blocking here would
    // collapse the synchronizer stages into one.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_filt     <= 1'b0;
            r_filt_cnt <= 8'd0;
            r_filt_d   <= 1'b0;
            r_rise     <= 1'b0;
        end else begin
            r_sync1 <= sensor_in;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_filt) begin
                r_filt_cnt <= 8'd0;
            end else if (r_filt_cnt == FILT_LAST) begin
                r_filt     <= r_sync2;
                r_filt_cnt <= 8'd0;
            end else begin
                r_filt_cnt <= r_filt_cnt + 8'd1;
            end
            r_filt_d <= r_filt;
            r_rise   <= r_filt & ~r_filt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-window values. w_cnt_next already includes an edge arriving in the
    // same cycle as tick_in, so that edge lands in the closing window.
    // -------------------------------------------------------------------------
    // NOTE: each always_comb output gets a default assignment first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_cnt_next   = r_win_cnt;
        w_stall_next = 8'd0;
        if (r_rise && (r_win_cnt != CNT_MAX)) begin
            w_cnt_next = r_win_cnt + CNT_WIDTH'(1);
        end
        if (w_cnt_next == '0) begin
            w_stall_next = (r_stall_cnt == STALL_MAX) ? r_stall_cnt
                                                      : r_stall_cnt + 8'd1;
        end
    end

    assign w_win_sat = (w_cnt_next == CNT_MAX);

    // -------------------------------------------------------------------------
    // Measurement FSM. Dropping enable returns to IDLE from any state and
    // discards the partial window; published outputs hold. The first tick
    // after enabling only arms the first window.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state       <= IDLE;
            r_win_cnt     <= '0;
            r_stall_cnt   <= 8'd0;
            r_count_out   <= '0;
            r_count_valid <= 1'b0;
            r_overflow    <= 1'b0;
            r_stalled     <= 1'b0;
        end else begin
            r_count_valid <= 1'b0;
            if (!enable) begin
                r_state   <= IDLE;
                r_win_cnt <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        // tick_in on the enable-rising cycle is ignored
                        r_state   <= ARM;
                        r_win_cnt <= '0;
                    end
                    ARM: begin
                        r_win_cnt <= '0;
                        if (tick_in) begin
                            r_state <= MEASURE;
                        end
                    end
                    MEASURE: begin
                        if (tick_in) begin
                            r_count_out   <= w_cnt_next;
                            r_overflow    <= w_win_sat;
                            r_count_valid <= 1'b1;
                            r_stall_cnt   <= w_stall_next;
                            r_stalled     <= (w_stall_next == STALL_MAX);
                            r_win_cnt     <= '0;
                        end else begin
                            r_win_cnt <= w_cnt_next;
                        end
                    end
                    default: begin
                        r_state   <= IDLE;
                        r_win_cnt <= '0;
                    end
                endcase
            end
        end
    end

    assign count_out   = r_count_out;
    assign count_valid = r_count_valid;
    assign overflow    = r_overflow;
    assign stalled     = r_stalled;

endmodule

// File: tb/tb_tacometro.sv
// -----------------------------------------------------------------------------
// tb_tacometro -- directed bench for tacometro
//
// Two instances share all stimulus: dut16 (defaults) and dut4 (CNT_WIDTH=4)
// so saturation can be checked against the unsaturated count of the same
// window. Inputs change 1 time unit after a rising edge; outputs are sampled
// at the same point, away from the active edge.
// -----------------------------------------------------------------------------
module tb_tacometro;

    logic        clk_in = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        tick_in = 1'b0;
    logic        sensor_in = 1'b0;

    logic [15:0] cnt16;
    logic        cv16, ov16, st16;
    logic [3:0]  cnt4;
    logic        cv4, ov4, st4;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk_in = ~clk_in;

    tacometro dut16 (
        .clk_in(clk_in), .rst(rst), .enable(enable), .tick_in(tick_in),
        .sensor_in(sensor_in), .count_out(cnt16), .count_valid(cv16),
        .overflow(ov16), .stalled(st16)
    );

    tacometro #(.CNT_WIDTH(4), .FILTER_LEN(4), .STALL_WINDOWS(3)) dut4 (
        .clk_in(clk_in), .rst(rst), .enable(enable), .tick_in(tick_in),
        .sensor_in(sensor_in), .count_out(cnt4), .count_valid(cv4),
        .overflow(ov4), .stalled(st4)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic pulses(input int n, input int hi, input int lo);
        for (int i = 0; i < n; i++) begin
            sensor_in = 1'b1;
            step(hi);
            sensor_in = 1'b0;
            step(lo);
        end
    endtask

    // Tick that must publish: checks both instances, then the pulse width.
    task automatic publish(input string tag, input int e16, input int eo16,
                           input int e4, input int eo4, input int est);
        tick_in = 1'b1;
        step(1);
        tick_in = 1'b0;
        check({tag, ".cv16"}, 32'(cv16), 1);
        check({tag, ".cnt16"}, 32'(cnt16), e16);
        check({tag, ".ov16"}, 32'(ov16), eo16);
        check({tag, ".st16"}, 32'(st16), est);
        check({tag, ".cv4"}, 32'(cv4), 1);
        check({tag, ".cnt4"}, 32'(cnt4), e4);
        check({tag, ".ov4"}, 32'(ov4), eo4);
        check({tag, ".st4"}, 32'(st4), est);
        step(1);
        check({tag, ".cv_off"}, 32'(cv16 | cv4), 0);
    endtask

    // Tick that must not publish (arming tick).
    task automatic silent_tick(input string tag);
        tick_in = 1'b1;
        step(1);
        tick_in = 1'b0;
        check({tag, ".cv"}, 32'(cv16 | cv4), 0);
    endtask

    initial begin
        logic seen_cv;

        // Reset state
        step(3);
        rst = 1'b0;
        check("rst.cnt16", 32'(cnt16), 0);
        check("rst.cv16", 32'(cv16), 0);
        check("rst.ov16", 32'(ov16), 0);
        check("rst.st16", 32'(st16), 0);
        check("rst.cnt4", 32'(cnt4), 0);

        // Tick coincident with enable rising is ignored; next tick only arms
        enable  = 1'b1;
        tick_in = 1'b1;
        step(1);
        tick_in = 1'b0;
        check("en_tick.cv", 32'(cv16), 0);
        step(5);
        silent_tick("arm1");
        check("arm1.cnt16", 32'(cnt16), 0);

        // Five clean pulses
        pulses(5, 50, 50);
        step(10);
        publish("clean5", 5, 0, 5, 0, 0);

        // 3-cycle glitches are filtered out
        pulses(5, 3, 10);
        publish("glitch", 0, 0, 0, 0, 0);

        // A pulse held exactly FILTER_LEN cycles is accepted
        pulses(1, 4, 20);
        publish("minpulse", 1, 0, 1, 0, 0);

        // Tick one cycle before the increment: edge goes to the next window
        sensor_in = 1'b1;
        step(6);
        publish("early", 0, 0, 0, 0, 0);
        step(18);
        sensor_in = 1'b0;
        step(20);
        publish("early_next", 1, 0, 1, 0, 0);

        // Tick coincident with the increment (7 cycles after first sample)
        sensor_in = 1'b1;
        step(7);
        publish("coinc", 1, 0, 1, 0, 0);
        step(18);
        sensor_in = 1'b0;
        step(20);
        publish("coinc_next", 0, 0, 0, 0, 0);

        // Stall: third consecutive zero window raises stalled
        step(10);
        publish("zero2", 0, 0, 0, 0, 0);
        step(10);
        publish("zero3", 0, 0, 0, 0, 1);
        pulses(2, 20, 20);
        publish("unstall", 2, 0, 2, 0, 0);

        // Saturation on the 4-bit instance
        pulses(20, 10, 10);
        publish("sat20", 20, 0, 15, 1, 0);
        pulses(3, 10, 10);
        publish("after_sat", 3, 0, 3, 0, 0);
        pulses(20, 10, 10);
        publish("sat20b", 20, 0, 15, 1, 0);

        // enable dropped mid-window: no publish, outputs hold
        pulses(2, 10, 10);
        enable  = 1'b0;
        seen_cv = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step(1);
            if (i == 10) tick_in = 1'b1;
            if (i == 11) tick_in = 1'b0;
            seen_cv = seen_cv | cv16 | cv4;
        end
        check("dis.no_cv", 32'(seen_cv), 0);
        check("dis.cnt4", 32'(cnt4), 15);
        check("dis.ov4", 32'(ov4), 1);
        check("dis.cnt16", 32'(cnt16), 20);
        enable = 1'b1;
        step(3);
        silent_tick("rearm");
        pulses(1, 10, 10);
        publish("rearm_win", 1, 0, 1, 0, 0);
        pulses(20, 10, 10);
        publish("sat20c", 20, 0, 15, 1, 0);

        // rst mid-window: outputs cleared, no publish, re-arm needed
        pulses(2, 10, 10);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("mrst.cnt16", 32'(cnt16), 0);
        check("mrst.cnt4", 32'(cnt4), 0);
        check("mrst.ov4", 32'(ov4), 0);
        check("mrst.cv", 32'(cv16 | cv4), 0);
        seen_cv = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            seen_cv = seen_cv | cv16 | cv4;
        end
        check("mrst.no_cv", 32'(seen_cv), 0);
        silent_tick("rearm_rst");
        pulses(2, 10, 10);
        publish("post_rst", 2, 0, 2, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tacometro.md
TACOMETRO -- requirements
Module: tacometro

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 16: width of pulse count per window.
REQ-002 SHALL have parameter FILTER_LEN, default 4: clk_in cycles a synchronized sensor level must hold to be accepted (valid range 1..255).
REQ-003 SHALL have parameter STALL_WINDOWS, default 3: consecutive zero-count windows that flag a stalled motor (valid range 1..255).
REQ-004 SHALL have port clk_in, input, 1: system clock; all logic on posedge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port enable, input, 1: measurement enable, synchronous to clk_in.
REQ-007 SHALL have port tick_in, input, 1: one-cycle window strobe from the clock divider, synchronous to clk_in.
REQ-008 SHALL have port sensor_in, input, 1: raw asynchronous speed-sensor pulse input.
REQ-009 SHALL have port count_out, output, CNT_WIDTH: rising sensor edges counted in the last completed window.
REQ-010 SHALL have port count_valid, output, 1: one-cycle pulse when count_out is updated.
REQ-011 SHALL have port overflow, output, 1: last completed window saturated.
REQ-012 SHALL have port stalled, output, 1: motor stalled indication.

Function
REQ-013 SHALL pass sensor_in through a 2-flop synchronizer before any other use.
REQ-014 SHALL change the filtered level only after the synchronized level differs from it for FILTER_LEN consecutive cycles; shorter glitches SHALL be ignored.
REQ-015 SHALL count only rising edges of the filtered level; latency from the first clk_in edge sampling sensor_in high (held stable) to window counter increment SHALL be exactly FILTER_LEN+3 cycles.
REQ-016 SHALL implement FSM states IDLE, ARM, MEASURE; reset state IDLE.
REQ-017 IDLE -> ARM when enable=1; ARM -> MEASURE on tick_in=1 (window counter cleared, nothing published); MEASURE stays on each tick_in.
REQ-018 Any state -> IDLE on the cycle enable=0; partial window count discarded; count_out, overflow, stalled hold their values.
REQ-019 In MEASURE, on tick_in=1, SHALL register count_out = window count, overflow = saturation flag, and assert count_valid on the next cycle for exactly one cycle.
REQ-020 Edge increment and tick_in in the same cycle: edge SHALL be counted in the closing window; new window SHALL start at 0.
REQ-021 Window counter SHALL saturate at 2^CNT_WIDTH-1, never wrap; reaching saturation sets the window's overflow flag.
REQ-022 tick_in in IDLE or coincident with the enable rising cycle SHALL be ignored; tick_in in ARM SHALL start the first window only.
REQ-023 Stall counter SHALL increment (saturating at STALL_WINDOWS) on each published zero-count window, clear on each published non-zero window; stalled=1 while it equals STALL_WINDOWS, updated with count_valid.
REQ-024 count_valid SHALL never assert outside MEASURE.

Reset
REQ-025 rst=1 SHALL force state IDLE, synchronizer, filter, window counter and stall counter to 0 on the next clk_in edge, overriding all other inputs.
REQ-026 After reset count_out=0, count_valid=0, overflow=0, stalled=0.
REQ-027 rst mid-window SHALL discard the window with no count_valid pulse; after rst releases, behaviour restarts from IDLE.

Verification
REQ-028 FILTER_LEN=4, enable=1, ticks every 1000 cycles, 5 clean pulses (50 high/50 low) in window 2 -> first tick arms only; second tick gives count_out=5, count_valid one cycle.
REQ-029 3-cycle high glitches on sensor_in within a window -> count_out=0; a 4-cycle-stable high pulse -> count_out=1 with increment exactly 7 cycles after first high sample.
REQ-030 CNT_WIDTH=4, 20 pulses in one window -> count_out=15, overflow=1; next window 3 pulses -> count_out=3, overflow=0.
REQ-031 Edge increment coincident with tick_in -> edge appears in closing window's count_out; following window starts at 0.
REQ-032 STALL_WINDOWS=3, three zero-count windows -> stalled=1 with the third count_valid; one window with 2 pulses -> stalled=0.
REQ-033 enable dropped mid-window, and separately rst mid-window -> no count_valid; outputs hold (enable) or go to 0 (rst); re-enable requires an arming tick.
